// File: rtl/ifetch_if.sv
// Instruction-memory port of the fetch unit: one request/acknowledge pair plus address and read data.
// imem_req is held high while a fetch is outstanding; imem_rdata is taken on the edge where imem_ack is high.
interface ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: IDLE -> REQ -> ISSUE loop, next-PC selection, HALT on misaligned target.
// Optional macro IFETCH_TIMEOUT_EN adds a 16-cycle acknowledge timeout in REQ that also halts.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_data,
    input  logic        stall,
    ifetch_if.master    imem,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  Funct,
    output logic [15:0] imm16,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d, instr_d, npc;
`ifdef IFETCH_TIMEOUT_EN
    logic [3:0]  cnt_q, cnt_d;
`endif

    assign OP             = instr[31:26];
    assign Funct          = instr[5:0];
    assign imm16          = instr[15:0];
    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;
    assign state_dbg      = state_q;

    always_comb begin
        case (npc_op)
            2'b00:   npc = pc_plus4;
            2'b01:   npc = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
            2'b10:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: npc = rs_data;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc;
        instr_d       = instr;
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        fetch_err     = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
`ifdef IFETCH_TIMEOUT_EN
                cnt_d   = 4'd0;
`endif
            end
            REQ: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = ISSUE;
                end
`ifdef IFETCH_TIMEOUT_EN
                // cnt_q==15 means this is the 16th consecutive cycle without ack
                else if (cnt_q == 4'hF) begin
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    pc_d = npc;
                    if (npc[1:0] != 2'b00) begin
                        state_d = HALT;
                    end else begin
                        state_d = REQ;
`ifdef IFETCH_TIMEOUT_EN
                        cnt_d   = 4'd0;
`endif
                    end
                end
            end
            default: begin
                fetch_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc      <= RESET_PC;
            instr   <= 32'd0;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            instr   <= instr_d;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed steps plus randomized fetches checked against a transaction-level PC model.
// The memory side is played by the bench; expected fetch addresses live in exp_q.
module tb_ifetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  npc_op;
    logic [31:0] rs_data;
    logic        stall;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  OP, Funct;
    logic [15:0] imm16;
    logic        instr_valid, fetch_err;
    logic [1:0]  state_dbg;

    ifetch_if imem_bus ();

    ifetch dut (
        .clk(clk), .rst(rst), .npc_op(npc_op), .rs_data(rs_data), .stall(stall),
        .imem(imem_bus.master),
        .instr(instr), .OP(OP), .Funct(Funct), .imm16(imm16),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_err(fetch_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next fetch address from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] model_npc(input logic [1:0] op, input logic [31:0] p,
                                              input logic [31:0] w, input logic [31:0] rs);
        logic [31:0] link;
        int          off;
        link = p + 32'd4;
        off  = $signed(w[15:0]);
        case (op)
            2'd0:    return link;
            2'd1:    return link + 32'(off * 4);
            2'd2:    return (link & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
            default: return rs;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        imem_bus.imem_ack = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_valid", instr_valid, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_req", imem_bus.imem_req, 0);
        chk("rst_instr", instr, 0);
        rst = 1'b1;
        chk("rel_req0", imem_bus.imem_req, 0);
        tick();
        chk("rel_req1", imem_bus.imem_req, 1);
        exp_q = {};
        exp_q.push_back(32'h0000_3000);
    endtask

    task automatic chk_issue(input string tag, input logic [31:0] word, input logic [31:0] p);
        chk({tag, "_valid"}, instr_valid, 1);
        chk({tag, "_req"}, imem_bus.imem_req, 0);
        chk({tag, "_instr"}, instr, word);
        chk({tag, "_op"}, OP, word >> 26);
        chk({tag, "_funct"}, Funct, word & 32'h3F);
        chk({tag, "_imm"}, imm16, word & 32'hFFFF);
        chk({tag, "_pc"}, pc, p);
        chk({tag, "_pc4"}, pc_plus4, p + 32'd4);
    endtask

    task automatic do_fetch(input int ack_delay, input logic [31:0] word, input int stall_cyc,
                            input logic [1:0] op, input logic [31:0] rs);
        logic [31:0] exp_pc, nxt;
        exp_pc = exp_q.pop_front();
        chk("fetch_req", imem_bus.imem_req, 1);
        chk("fetch_addr", imem_bus.imem_addr, exp_pc);
        repeat (ack_delay) begin
            tick();
            chk("wait_req", imem_bus.imem_req, 1);
            chk("wait_err", fetch_err, 0);
        end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = word;
        tick();
        chk_issue("issue", word, exp_pc);
        stall = 1'b1;
        repeat (stall_cyc) begin
            // acks during ISSUE must not disturb the latched word
            imem_bus.imem_ack = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom;
            npc_op = 2'($urandom_range(0, 3));
            tick();
            chk_issue("stall", word, exp_pc);
        end
        imem_bus.imem_ack = 1'b0;
        stall = 1'b0;
        npc_op = op;
        rs_data = rs;
        tick();
        nxt = model_npc(op, exp_pc, word, rs);
        chk("next_pc", pc, nxt);
        if (nxt[1:0] == 2'b00) begin
            chk("next_req", imem_bus.imem_req, 1);
            chk("next_valid", instr_valid, 0);
            exp_q.push_back(nxt);
        end else begin
            chk("halt_req", imem_bus.imem_req, 0);
            chk("halt_err", fetch_err, 1);
            chk("halt_valid", instr_valid, 0);
        end
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b0;
        npc_op = 2'b00;
        rs_data = 32'd0;
        stall = 1'b0;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = 32'd0;

        do_reset();

        // Sequential fetch with immediate ack: 0x3000, 0x3004, 0x3008, 0x300C, then 0x3010
        repeat (4) do_fetch(0, $urandom, 0, 2'b00, 32'd0);
        chk("seq_pc", pc, 32'h0000_3010);
        // Branch back by two words from 0x3010
        do_fetch(0, 32'h1234_FFFE, 0, 2'b01, 32'd0);
        chk("br_pc", pc, 32'h0000_300C);
        // jr to 0x3000 then jump with target field 0xC10
        do_fetch(1, $urandom, 0, 2'b11, 32'h0000_3000);
        do_fetch(0, 32'h0800_0C10, 0, 2'b10, 32'd0);
        chk("jmp_pc", pc, 32'h0000_3040);
        // Stall three cycles, then a single advance
        do_fetch(0, $urandom, 3, 2'b00, 32'd0);
        chk("stall_pc", pc, 32'h0000_3044);
        // Top-of-memory wrap of the link value
        do_fetch(0, $urandom, 0, 2'b11, 32'hFFFF_FFFC);
        do_fetch(0, $urandom, 0, 2'b00, 32'd0);
        chk("wrap_pc", pc, 32'h0000_0000);

        // Randomized fetch stream, targets kept word aligned
        for (int i = 0; i < 60; i++) begin
            do_fetch($urandom_range(0, 6), $urandom, $urandom_range(0, 3),
                     2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC);
        end

        // Ack withheld for 20 cycles
        do_reset();
`ifdef IFETCH_TIMEOUT_EN
        repeat (15) begin
            tick();
            chk("to_req", imem_bus.imem_req, 1);
            chk("to_err0", fetch_err, 0);
        end
        tick();
        chk("to_err1", fetch_err, 1);
        chk("to_req0", imem_bus.imem_req, 0);
        imem_bus.imem_ack = 1'b1;
        repeat (4) begin
            tick();
            chk("to_hold_err", fetch_err, 1);
            chk("to_hold_valid", instr_valid, 0);
        end
        imem_bus.imem_ack = 1'b0;
        do_reset();
`else
        do_fetch(19, 32'hCAFE_0004, 0, 2'b00, 32'd0);
        chk("late_err", fetch_err, 0);
`endif

        // Misaligned jr target halts until reset, ignoring ack
        do_reset();
        do_fetch(0, $urandom, 0, 2'b11, 32'h0000_3002);
        chk("mis_pc", pc, 32'h0000_3002);
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        repeat (5) begin
            tick();
            chk("mis_req", imem_bus.imem_req, 0);
            chk("mis_err", fetch_err, 1);
            chk("mis_valid", instr_valid, 0);
        end
        imem_bus.imem_ack = 1'b0;

        // Reset wins over a simultaneous ack
        do_reset();
        do_fetch(0, 32'h0000_0123, 0, 2'b00, 32'd0);
        rst = 1'b0;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h5555_AAAA;
        tick();
        chk("rp_instr", instr, 0);
        chk("rp_valid", instr_valid, 0);
        chk("rp_req", imem_bus.imem_req, 0);
        chk("rp_pc", pc, 32'h0000_3000);
        imem_bus.imem_ack = 1'b0;
        rst = 1'b1;
        tick();
        chk("rp_req1", imem_bus.imem_req, 1);
        chk("rp_addr", imem_bus.imem_addr, 32'h0000_3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
